// File: rtl/dft_tdm_accumulator.sv
// Time-multiplexed DFT accumulator: NUM_LANES complex MACs reused across NUM_BINS bins, results drained per bin.
// Optional saturating accumulation is enabled by defining DFT_ACC_SATURATE_EN.
module dft_tdm_accumulator #(
    parameter int IQ_WIDTH           = 16,
    parameter int WINDOW_WIDTH       = 16,
    parameter int OSC_WIDTH          = 27,
    parameter int ACCUM_WIDTH        = 48,
    parameter int NUM_BINS           = 16,
    parameter int NUM_LANES          = 4,
    parameter int PROD_SHIFT         = 13,
    parameter int SAMPLE_COUNT_WIDTH = 16,
    localparam int G                 = NUM_BINS / NUM_LANES,
    localparam int GW                = (G > 1) ? $clog2(G) : 1,
    localparam int BIN_W             = $clog2(NUM_BINS)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 start_i,
    input  logic                                 abort_i,
    input  logic                                 in_valid_i,
    output logic                                 in_ready_o,
    input  logic                                 in_last_i,
    input  logic signed [IQ_WIDTH-1:0]           i_sample_i,
    input  logic signed [IQ_WIDTH-1:0]           q_sample_i,
    input  logic signed [WINDOW_WIDTH-1:0]       window_coeff_i,
    output logic [GW-1:0]                        w_group_o,
    output logic [SAMPLE_COUNT_WIDTH-1:0]        w_sample_idx_o,
    input  logic signed [OSC_WIDTH-1:0]          W_real_i [NUM_LANES],
    input  logic signed [OSC_WIDTH-1:0]          W_imag_i [NUM_LANES],
    output logic                                 out_valid_o,
    input  logic                                 out_ready_i,
    output logic [BIN_W-1:0]                     out_bin_o,
    output logic signed [ACCUM_WIDTH-1:0]        out_real_o,
    output logic signed [ACCUM_WIDTH-1:0]        out_imag_o,
    output logic                                 out_last_o,
    output logic [SAMPLE_COUNT_WIDTH-1:0]        sample_count_o,
    output logic                                 busy_o,
    output logic                                 overflow_o
);

    localparam int XW = IQ_WIDTH + WINDOW_WIDTH;
    localparam int PW = XW + OSC_WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_FLUSH,
        S_DRAIN
    } state_t;

    state_t state, state_nxt;

    logic                          accept;
    logic                          last_seen;
    logic                          seq_active;
    logic                          issue_last;
    logic [GW-1:0]                 seq_group;
    logic [SAMPLE_COUNT_WIDTH-1:0] sample_count;
    logic [SAMPLE_COUNT_WIDTH-1:0] sample_idx;
    logic signed [XW-1:0]          x_re, x_im;
    logic [BIN_W-1:0]              out_bin;

    // Oscillator stage: W and the windowed sample travel together so a new accept cannot disturb group G-1
    logic                          st_valid;
    logic [GW-1:0]                 st_group;
    logic signed [XW-1:0]          st_x_re, st_x_im;
    logic signed [OSC_WIDTH-1:0]   st_w_re [NUM_LANES];
    logic signed [OSC_WIDTH-1:0]   st_w_im [NUM_LANES];

    logic signed [ACCUM_WIDTH-1:0] acc_re [NUM_BINS];
    logic signed [ACCUM_WIDTH-1:0] acc_im [NUM_BINS];

    logic [BIN_W-1:0]              lane_bin [NUM_LANES];
    logic signed [PW-1:0]          prod_re [NUM_LANES];
    logic signed [PW-1:0]          prod_im [NUM_LANES];
    logic signed [ACCUM_WIDTH-1:0] nxt_re [NUM_LANES];
    logic signed [ACCUM_WIDTH-1:0] nxt_im [NUM_LANES];

    function automatic logic signed [ACCUM_WIDTH-1:0] scale(input logic signed [PW-1:0] p);
        return ACCUM_WIDTH'(p >>> PROD_SHIFT);
    endfunction

`ifdef DFT_ACC_SATURATE_EN
    logic [NUM_LANES-1:0] ovf_re, ovf_im;
    logic                 overflow_q;

    function automatic logic [ACCUM_WIDTH:0] sat_add(input logic signed [ACCUM_WIDTH-1:0] a,
                                                     input logic signed [ACCUM_WIDTH-1:0] b);
        logic [ACCUM_WIDTH:0] s;
        s = {a[ACCUM_WIDTH-1], a} + {b[ACCUM_WIDTH-1], b};
        if (s[ACCUM_WIDTH] != s[ACCUM_WIDTH-1])
            return {1'b1, s[ACCUM_WIDTH], {(ACCUM_WIDTH-1){~s[ACCUM_WIDTH]}}};
        return {1'b0, s[ACCUM_WIDTH-1:0]};
    endfunction
`endif

    assign issue_last  = seq_active && (seq_group == GW'(G - 1));
    assign in_ready_o  = (state == S_ACCUM) && !last_seen && (!seq_active || issue_last);
    assign accept      = in_valid_i && in_ready_o;

    assign w_group_o      = seq_group;
    assign w_sample_idx_o = seq_active ? sample_idx : '0;
    assign sample_count_o = sample_count;
    assign busy_o         = (state != S_IDLE);
    assign out_valid_o    = (state == S_DRAIN);
    assign out_bin_o      = out_bin;
    assign out_last_o     = out_valid_o && (out_bin == BIN_W'(NUM_BINS - 1));
    assign out_real_o     = out_valid_o ? acc_re[out_bin] : '0;
    assign out_imag_o     = out_valid_o ? acc_im[out_bin] : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (start_i) state_nxt = S_ACCUM;
            S_ACCUM: if (last_seen && issue_last) state_nxt = S_FLUSH;
            S_FLUSH: if (!seq_active) state_nxt = S_DRAIN;
            S_DRAIN: if (out_ready_i && out_last_o) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (abort_i) state_nxt = S_IDLE;
    end

    always_comb begin
`ifdef DFT_ACC_SATURATE_EN
        ovf_re = '0;
        ovf_im = '0;
`endif
        for (int l = 0; l < NUM_LANES; l++) begin
            lane_bin[l] = BIN_W'(BIN_W'(st_group) * BIN_W'(NUM_LANES) + BIN_W'(l));
            prod_re[l]  = PW'(st_x_re) * PW'(st_w_re[l]) - PW'(st_x_im) * PW'(st_w_im[l]);
            prod_im[l]  = PW'(st_x_re) * PW'(st_w_im[l]) + PW'(st_x_im) * PW'(st_w_re[l]);
`ifdef DFT_ACC_SATURATE_EN
            {ovf_re[l], nxt_re[l]} = sat_add(acc_re[lane_bin[l]], scale(prod_re[l]));
            {ovf_im[l], nxt_im[l]} = sat_add(acc_im[lane_bin[l]], scale(prod_im[l]));
`else
            nxt_re[l] = acc_re[lane_bin[l]] + scale(prod_re[l]);
            nxt_im[l] = acc_im[lane_bin[l]] + scale(prod_im[l]);
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_seen    <= 1'b0;
            seq_active   <= 1'b0;
            seq_group    <= '0;
            sample_count <= '0;
            sample_idx   <= '0;
            x_re         <= '0;
            x_im         <= '0;
            out_bin      <= '0;
            st_valid     <= 1'b0;
            st_group     <= '0;
            st_x_re      <= '0;
            st_x_im      <= '0;
            for (int l = 0; l < NUM_LANES; l++) begin
                st_w_re[l] <= '0;
                st_w_im[l] <= '0;
            end
            for (int k = 0; k < NUM_BINS; k++) begin
                acc_re[k] <= '0;
                acc_im[k] <= '0;
            end
        end else if (abort_i) begin
            // accumulators are left stale on purpose; the next start clears them
            last_seen  <= 1'b0;
            seq_active <= 1'b0;
            seq_group  <= '0;
            st_valid   <= 1'b0;
        end else begin
            if (accept) begin
                x_re         <= XW'(i_sample_i) * XW'(window_coeff_i);
                x_im         <= XW'(q_sample_i) * XW'(window_coeff_i);
                sample_idx   <= sample_count;
                sample_count <= sample_count + SAMPLE_COUNT_WIDTH'(1);
                seq_active   <= 1'b1;
                seq_group    <= '0;
                if (in_last_i) last_seen <= 1'b1;
            end else if (seq_active) begin
                seq_active <= !issue_last;
                seq_group  <= issue_last ? '0 : seq_group + GW'(1);
            end

            st_valid <= seq_active;
            if (seq_active) begin
                st_group <= seq_group;
                st_x_re  <= x_re;
                st_x_im  <= x_im;
                st_w_re  <= W_real_i;
                st_w_im  <= W_imag_i;
            end

            if (st_valid) begin
                for (int l = 0; l < NUM_LANES; l++) begin
                    acc_re[lane_bin[l]] <= nxt_re[l];
                    acc_im[lane_bin[l]] <= nxt_im[l];
                end
            end

            if (out_valid_o && out_ready_i)
                out_bin <= out_last_o ? '0 : out_bin + BIN_W'(1);

            if (state == S_IDLE && start_i) begin
                last_seen    <= 1'b0;
                sample_count <= '0;
                out_bin      <= '0;
                for (int k = 0; k < NUM_BINS; k++) begin
                    acc_re[k] <= '0;
                    acc_im[k] <= '0;
                end
            end
        end
    end

`ifdef DFT_ACC_SATURATE_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            overflow_q <= 1'b0;
        else if (state == S_IDLE && start_i && !abort_i)
            overflow_q <= 1'b0;
        else if (!abort_i && st_valid && (|ovf_re || |ovf_im))
            overflow_q <= 1'b1;
    end
    assign overflow_o = overflow_q;
`else
    assign overflow_o = 1'b0;
`endif

endmodule
